multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 165 ++++++++++++++++
 tb/tb_multicycle_datapath.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle ARM-style datapath: IR/PC, 16-entry register file (R15 reads PC+4), ALU and muxes.
// Optional barrel shifter on the register SrcB path is enabled by defining MCDP_SHIFTER_EN.

module mcdp_alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   ctrl,
  output logic [W-1:0] y,
  output logic [3:0]   flags
);
  logic [W:0]   sum;
  logic [W-1:0] b_eff;
  logic         c, v;

  // SUB is a + ~b + 1, so C=1 means no borrow
  always_comb begin
    b_eff = ctrl[0] ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, ctrl[0]};
    y     = sum[W-1:0];
    c     = 1'b0;
    v     = 1'b0;
    case (ctrl)
      2'b00, 2'b01: begin
        y = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
      end
      2'b10:   y = a & b;
      default: y = a | b;
    endcase
  end

  assign flags = {y[W-1], (y == '0), c, v};
endmodule

module multicycle_datapath #(
  parameter int           W        = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [W-1:0] ReadData,
  input  logic         PCWrite,
  input  logic         AdrSrc,
  input  logic         IRWrite,
  input  logic         RegWrite,
  input  logic         ALUSrcA,
  input  logic [1:0]   ALUSrcB,
  input  logic [1:0]   ResultSrc,
  input  logic [1:0]   ALUCtrl,
  input  logic [1:0]   RegSrc,
  input  logic [1:0]   ImmSrc,
  output logic [W-1:0] Adr,
  output logic [W-1:0] WriteData,
  output logic [31:0]  Instr,
  output logic [3:0]   ALUFlags,
  output logic [W-1:0] PC
);
  logic [W-1:0]        data, a, b, alu_out;
  logic [W-1:0]        alu_result, result, pc_plus4;
  logic [W-1:0]        ext_imm, src_a, src_b, b_sh;
  logic [3:0]          ra1, ra2, wa;
  logic [14:0][W-1:0]  rf;
  logic [15:0][W-1:0]  rf_view;
  logic [W-1:0]        rd1, rd2;

  assign pc_plus4 = PC + W'(4);
  assign ra1      = RegSrc[0] ? 4'hF : Instr[19:16];
  assign ra2      = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  assign wa       = Instr[15:12];

  // R15 is not storage: it aliases PC+4, so writes to it fall on the floor
  assign rf_view = {pc_plus4, rf};
  assign rd1     = rf_view[ra1];
  assign rd2     = rf_view[ra2];

  for (genvar i = 0; i < 15; i++) begin : g_rf
    always_ff @(posedge clk or negedge Reset) begin
      if (!Reset)                       rf[i] <= '0;
      else if (RegWrite && wa == 4'(i)) rf[i] <= result;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      Instr   <= '0;
      PC      <= RESET_PC;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      if (IRWrite) Instr <= ReadData[31:0];
      if (PCWrite) PC    <= result;
      data    <= ReadData;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
    end
  end

  always_comb begin
    ext_imm = '0;
    case (ImmSrc)
      2'b00:   ext_imm = W'(Instr[7:0]);
      2'b01:   ext_imm = W'(Instr[11:0]);
      2'b10:   ext_imm = {{(W-26){Instr[23]}}, Instr[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

`ifdef MCDP_SHIFTER_EN
  logic [4:0] shamt;
  logic [6:0] ror_l;
  assign shamt = Instr[11:7];
  assign ror_l = 7'(W) - 7'(shamt);

  // a shift of 0 makes the ROR left term shift by W, which yields zero
  always_comb begin
    b_sh = b;
    case (Instr[6:5])
      2'b00:   b_sh = b << shamt;
      2'b01:   b_sh = b >> shamt;
      2'b10:   b_sh = $signed(b) >>> shamt;
      default: b_sh = (b >> shamt) | (b << ror_l);
    endcase
  end
`else
  assign b_sh = b;
`endif

  assign src_a = ALUSrcA ? PC : a;

  always_comb begin
    src_b = b_sh;
    case (ALUSrcB)
      2'b00:   src_b = b_sh;
      2'b01:   src_b = ext_imm;
      2'b10:   src_b = W'(4);
      default: src_b = '0;
    endcase
  end

  mcdp_alu #(.W(W)) u_alu (
    .a     (src_a),
    .b     (src_b),
    .ctrl  (ALUCtrl),
    .y     (alu_result),
    .flags (ALUFlags)
  );

  always_comb begin
    result = alu_out;
    case (ResultSrc)
      2'b01:   result = data;
      2'b10:   result = alu_result;
      default: result = alu_out;
    endcase
  end

  assign Adr       = AdrSrc ? result : PC;
  assign WriteData = b;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT ports.

module tb_multicycle_datapath;
  logic        clk, Reset;
  logic [31:0] ReadData;
  logic        PCWrite, AdrSrc, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ALUCtrl, RegSrc, ImmSrc;
  logic [31:0] Adr, WriteData, Instr, PC;
  logic [3:0]  ALUFlags;

  localparam int S_PC = 0, S_IR = 1, S_ADR = 2, S_WD = 3, S_FL = 4;

  typedef struct packed {
    logic [2:0]  sig;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    done   = 0;

`ifdef MCDP_SHIFTER_EN
  localparam logic [31:0] SHIFT_EXP = 32'hC000_0000;
`else
  localparam logic [31:0] SHIFT_EXP = 32'h8000_0001;
`endif

  multicycle_datapath #(.W(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .ReadData  (ReadData),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUCtrl   (ALUCtrl),
    .RegSrc    (RegSrc),
    .ImmSrc    (ImmSrc),
    .Adr       (Adr),
    .WriteData (WriteData),
    .Instr     (Instr),
    .ALUFlags  (ALUFlags),
    .PC        (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sel_out(input int sig);
    case (sig)
      S_PC:    return PC;
      S_IR:    return Instr;
      S_ADR:   return Adr;
      S_WD:    return WriteData;
      default: return {28'b0, ALUFlags};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = sel_out(int'(e.sig));
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e.val);
      end
    end
  end

  task automatic check_now(input int sig, input logic [31:0] v, input string nm);
    logic [31:0] act;
    act = sel_out(sig);
    n_chk++;
    if (act !== v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, v);
    end
  endtask

  task automatic expect_out(input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.sig = 3'(sig);
    e.val = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCWrite = 0; AdrSrc = 0; IRWrite = 0; RegWrite = 0; ALUSrcA = 0;
    ALUSrcB = 2'b00; ResultSrc = 2'b00; ALUCtrl = 2'b00; RegSrc = 2'b00; ImmSrc = 2'b00;
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle();
    IRWrite = 1; PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    ReadData = instr;
  endtask

  task automatic observe_a();
    idle();
    ALUSrcB = 2'b11; ResultSrc = 2'b10; AdrSrc = 1;
  endtask

  task automatic alu_op(input logic [1:0] srcb, input logic [1:0] imm, input logic [1:0] op);
    idle();
    ALUSrcB = srcb; ImmSrc = imm; ALUCtrl = op; ResultSrc = 2'b10; AdrSrc = 1;
  endtask

  task automatic load_reg_from_data();
    idle();
    RegWrite = 1; ResultSrc = 2'b01;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    Reset = 0; ReadData = '0; idle();
    #3;
    check_now(S_PC, 32'h0, "rst_pc_now");
    check_now(S_IR, 32'h0, "rst_instr_now");
    check_now(S_WD, 32'h0, "rst_wdata_now");
    check_now(S_ADR, 32'h0, "rst_adr_now");
    expect_out(S_PC, 32'h0, "rst_pc");
    expect_out(S_IR, 32'h0, "rst_instr");
    expect_out(S_WD, 32'h0, "rst_wdata");
    expect_out(S_ADR, 32'h0, "rst_adr");
    tick(); observe_a();
    expect_out(S_ADR, 32'h0, "rst_a");
    expect_out(S_FL, 32'h4, "rst_flags");

    tick(); Reset = 1; fetch(32'hE281_1005);
    expect_out(S_ADR, 32'h0, "fetch_adr");
    expect_out(S_FL, 32'h0, "fetch_flags");
    tick(); idle(); ReadData = 32'd7;
    expect_out(S_IR, 32'hE281_1005, "fetch_ir");
    expect_out(S_PC, 32'h4, "fetch_pc");
    tick(); load_reg_from_data(); ReadData = '0;
    tick(); observe_a(); expect_out(S_ADR, 32'h0, "a_prewrite");
    tick(); observe_a(); expect_out(S_ADR, 32'h7, "r1_init");
    tick(); alu_op(2'b01, 2'b00, 2'b00);
    expect_out(S_ADR, 32'd12, "add_imm_res");
    expect_out(S_FL, 32'h0, "add_imm_flags");
    tick(); idle(); RegWrite = 1; AdrSrc = 1;
    expect_out(S_ADR, 32'd12, "aluout");
    tick(); observe_a(); expect_out(S_ADR, 32'h7, "a_prewrite2");
    tick(); observe_a(); expect_out(S_ADR, 32'd12, "r1_wb");

    tick(); idle(); IRWrite = 1; ReadData = 32'hE242_2003;
    tick(); idle(); ReadData = 32'd3;
    expect_out(S_IR, 32'hE242_2003, "ir_load");
    expect_out(S_PC, 32'h4, "pc_hold");
    tick(); load_reg_from_data();
    tick(); idle();
    tick(); alu_op(2'b01, 2'b00, 2'b01); ReadData = 32'h8000_0000;
    expect_out(S_ADR, 32'h0, "sub_eq_res");
    expect_out(S_FL, 32'h6, "sub_eq_flags");
    tick(); load_reg_from_data();
    tick(); idle();
    tick(); alu_op(2'b01, 2'b00, 2'b01); RegSrc = 2'b10;
    expect_out(S_ADR, 32'h7FFF_FFFD, "sub_ovf_res");
    expect_out(S_FL, 32'h3, "sub_ovf_flags");
    tick(); alu_op(2'b00, 2'b00, 2'b00); RegSrc = 2'b10;
    expect_out(S_ADR, 32'h0, "add_carry_res");
    expect_out(S_FL, 32'h7, "add_carry_flags");
    expect_out(S_WD, 32'h8000_0000, "wdata_b");
    tick(); alu_op(2'b01, 2'b10, 2'b11);
    expect_out(S_ADR, 32'h8108_800C, "orr_imm24");
    expect_out(S_FL, 32'h8, "orr_flags");
    tick(); alu_op(2'b01, 2'b01, 2'b10);
    expect_out(S_ADR, 32'h0, "and_imm12");
    expect_out(S_FL, 32'h4, "and_flags");
    tick(); alu_op(2'b01, 2'b11, 2'b00);
    expect_out(S_ADR, 32'h8000_0000, "imm_zero");

    tick(); idle(); IRWrite = 1; ReadData = 32'hE083_40E4;
    tick(); idle(); ReadData = 32'h8000_0001;
    tick(); load_reg_from_data();
    tick(); idle();
    tick(); alu_op(2'b00, 2'b00, 2'b00);
    expect_out(S_ADR, SHIFT_EXP, "shift_ror");
    expect_out(S_WD, 32'h8000_0001, "wdata_b2");
    expect_out(S_FL, 32'h8, "shift_flags");
    tick(); alu_op(2'b01, 2'b10, 2'b00);
    expect_out(S_ADR, 32'hFE0D_0390, "imm24_neg");

    tick(); idle(); IRWrite = 1; ReadData = 32'hE28F_F000;
    tick(); idle(); ReadData = 32'h0000_0100;
    tick(); load_reg_from_data();
    tick(); idle(); RegSrc = 2'b11;
    expect_out(S_PC, 32'h4, "r15_pc_hold");
    tick(); observe_a();
    expect_out(S_ADR, 32'h8, "r15_read");
    expect_out(S_WD, 32'h8, "r15_rd2");

    tick(); idle(); PCWrite = 1; ResultSrc = 2'b01;
    tick(); idle(); ReadData = 32'hFFFF_FFFC;
    expect_out(S_PC, 32'h100, "pc_write");
    expect_out(S_ADR, 32'h100, "adr_pc");
    tick(); idle(); PCWrite = 1; ResultSrc = 2'b01;
    tick(); fetch(32'hE281_1005);
    expect_out(S_PC, 32'hFFFF_FFFC, "pc_max");
    expect_out(S_FL, 32'h6, "fetch_wrap_flags");
    tick(); idle(); ReadData = 32'h40;
    expect_out(S_PC, 32'h0, "pc_wrap");
    tick(); idle(); PCWrite = 1; ResultSrc = 2'b01;
    tick(); idle();
    expect_out(S_PC, 32'h40, "pc_40");

    tick(); Reset = 0; observe_a();
    expect_out(S_PC, 32'h0, "arst_pc");
    expect_out(S_IR, 32'h0, "arst_ir");
    expect_out(S_ADR, 32'h0, "arst_a");
    expect_out(S_WD, 32'h0, "arst_b");
    tick(); idle(); AdrSrc = 1;
    expect_out(S_ADR, 32'h0, "arst_aluout");
    tick(); Reset = 1; fetch(32'hE281_1005);
    expect_out(S_ADR, 32'h0, "post_rst_adr");
    tick(); idle();
    expect_out(S_PC, 32'h4, "post_rst_pc");
    expect_out(S_IR, 32'hE281_1005, "post_rst_ir");
    tick(); observe_a();
    expect_out(S_ADR, 32'h0, "r1_cleared");

    tick(); idle();
    tick();
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
